ram_port_master: RTL and testbench

- Initiator side of the single-port RAM interface.
- Accepts read, write and fill commands over a valid/ready request channel and drives the RAM port signals: data-in, address, and active-low write enable.
- The RAM commits writes and latches its address on the falling edge of clk; this block drives all RAM signals from rising-edge registers.
- Returns read data on a response channel; gives core logic a clean handshake instead of raw RAM timing.

---
 rtl/ram_port_master.sv | 132 +++++++++++++
 tb/tb_ram_port_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_master.sv
// rtl/ram_port_master.sv - single-port RAM initiator (read/write/fill); write-verify enabled by RAM_MASTER_VERIFY_EN
module ram_port_master #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_cmd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [ADDR_WIDTH-1:0] mem_addr_out
);
    localparam logic [1:0] CMD_RD   = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_FILL = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        FILL
`ifdef RAM_MASTER_VERIFY_EN
        , VRFY
`endif
    } state_t;

    state_t state;

    assign req_ready = (state == IDLE);

`ifdef RAM_MASTER_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // The RAM samples on the falling edge, so every RAM signal is registered on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_we      <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_addr    <= '0;
            done        <= 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        case (req_cmd)
                            CMD_RD: begin
                                mem_addr <= req_addr;
                                state    <= RD;
                            end
                            CMD_WR: begin
                                mem_addr    <= req_addr;
                                mem_data_in <= req_wdata;
                                mem_we      <= 1'b0;
                                state       <= WR;
                            end
                            CMD_FILL: begin
                                mem_addr    <= '0;
                                mem_data_in <= req_wdata;
                                mem_we      <= 1'b0;
                                state       <= FILL;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                WR: begin
                    mem_we <= 1'b1;
`ifdef RAM_MASTER_VERIFY_EN
                    state  <= VRFY;
`else
                    done   <= 1'b1;
                    state  <= IDLE;
`endif
                end
`ifdef RAM_MASTER_VERIFY_EN
                VRFY: begin
                    // mem_data_in still holds the written word and the RAM has re-latched mem_addr.
                    if (mem_data_out != mem_data_in) begin
                        err_q <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
`endif
                RD: begin
                    rsp_rdata <= mem_data_out;
                    rsp_addr  <= mem_addr_out;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                FILL: begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_we <= 1'b1;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                default: begin
                    mem_we <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_master.sv
// tb/tb_ram_port_master.sv - self-checking bench for ram_port_master; write-verify checks under RAM_MASTER_VERIFY_EN
module tb_ram_port_master;
    localparam int DW = 4;
    localparam int AW = 6;
    localparam int DEPTH = 64;
`ifdef RAM_MASTER_VERIFY_EN
    localparam int WLAT = 2;
`else
    localparam int WLAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cmd;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          done;
    logic          err;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_data_out;
    logic [AW-1:0] mem_addr_out;

    ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .done(done), .err(err),
        .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_data_out(mem_data_out), .mem_addr_out(mem_addr_out)
    );

    always #5 clk = ~clk;

    // RAM model: writes and address latch on the falling edge, optional stuck data_out bit 0.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_alat = '0;
    logic          stuck_en = 1'b0;
    always @(negedge clk) begin
        if (!mem_we) ram[mem_addr] = mem_data_in;
        ram_alat = mem_addr;
    end
    assign mem_addr_out = ram_alat;
    assign mem_data_out = stuck_en ? {ram[ram_alat][DW-1:1], 1'b0} : ram[ram_alat];

    logic [DW-1:0] exp_mem [DEPTH];
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input bit noise, output int lat, output int we_low, output int rdy_hi,
                          output logic [DW-1:0] rdata, output logic [AW-1:0] raddr, output bit got_rsp);
        int budget;
        budget = (cmd == 2'b11) ? 4 : 100;
        lat = -1; we_low = 0; rdy_hi = 0; rdata = '0; raddr = '0; got_rsp = 1'b0;
        check("ready_before_accept", int'(req_ready), 1);
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        for (int c = 1; c <= budget; c++) begin
            if (mem_we == 1'b0) we_low++;
            if (noise && c < 30) begin
                req_valid = 1'b1; req_cmd = 2'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (done || rsp_valid) begin
                lat = c; got_rsp = rsp_valid; rdata = rsp_rdata; raddr = rsp_addr;
                break;
            end
            if (req_ready) rdy_hi++;
        end
        req_valid = 1'b0;
        if (lat >= 0) begin
            check("pulse_exclusive", int'(done && rsp_valid), 0);
            step();
            check("pulse_one_cycle", int'(done || rsp_valid), 0);
        end
    endtask

    task automatic op(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input bit noise, input int exp_lat, input logic [DW-1:0] exp_rdata);
        int lat, we_low, rdy_hi;
        logic [DW-1:0] rdata;
        logic [AW-1:0] raddr;
        bit got_rsp;
        run_op(cmd, addr, wdata, noise, lat, we_low, rdy_hi, rdata, raddr, got_rsp);
        check($sformatf("latency cmd%0d", cmd), lat, exp_lat);
        check($sformatf("we_low_cycles cmd%0d", cmd), we_low, (cmd == 2'b10) ? DEPTH : (cmd == 2'b01) ? 1 : 0);
        if (cmd != 2'b11) check("ready_low_while_busy", rdy_hi, 0);
        if (cmd == 2'b00) begin
            check("rsp_is_read", int'(got_rsp), 1);
            check($sformatf("rsp_rdata addr%0d", addr), int'(rdata), int'(exp_rdata));
            check("rsp_addr", int'(raddr), int'(addr));
        end else if (cmd != 2'b11) begin
            check("done_not_rsp", int'(got_rsp), 0);
        end
        if (cmd == 2'b01) exp_mem[addr] = wdata;
        if (cmd == 2'b10) for (int i = 0; i < DEPTH; i++) exp_mem[i] = wdata;
    endtask

    initial begin
        int bad, r;
        logic [1:0] cmd;
        logic [AW-1:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = DW'(i) ^ 4'h5;
            exp_mem[i] = DW'(i) ^ 4'h5;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        repeat (3) step();
        check("rst mem_we", int'(mem_we), 1);
        check("rst mem_addr", int'(mem_addr), 0);
        check("rst mem_data_in", int'(mem_data_in), 0);
        check("rst outputs", int'({rsp_valid, rsp_rdata, rsp_addr, done, err}), 0);
        rst_n = 1'b1;
        step();
        check("ready after reset", int'(req_ready), 1);

        tbl[0] = '{2'b01, 6'd5,  4'hA, 4'h0, WLAT};
        tbl[1] = '{2'b00, 6'd5,  4'h0, 4'hA, 1};
        tbl[2] = '{2'b01, 6'd63, 4'hC, 4'h0, WLAT};
        tbl[3] = '{2'b00, 6'd63, 4'h0, 4'hC, 1};
        tbl[4] = '{2'b01, 6'd0,  4'h1, 4'h0, WLAT};
        tbl[5] = '{2'b00, 6'd0,  4'h0, 4'h1, 1};
        tbl[6] = '{2'b11, 6'd7,  4'hF, 4'h0, -1};
        tbl[7] = '{2'b00, 6'd7,  4'h0, 4'h2, 1};
        for (int i = 0; i < 8; i++) op(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_lat, tbl[i].exp_rdata);
        check("err after clean writes", int'(err), 0);

        // Back-to-back reads with req_valid held: second accept happens two edges later.
        req_valid = 1'b1; req_cmd = 2'b00; req_addr = 6'd0;
        step();
        req_addr = 6'd63;
        check("b2b busy", int'(req_ready), 0);
        step();
        check("b2b rsp0 valid", int'(rsp_valid), 1);
        check("b2b rsp0 data", int'(rsp_rdata), int'(exp_mem[0]));
        check("b2b rsp0 addr", int'(rsp_addr), 0);
        step();
        req_valid = 1'b0;
        check("b2b gap", int'(rsp_valid), 0);
        step();
        check("b2b rsp1 valid", int'(rsp_valid), 1);
        check("b2b rsp1 data", int'(rsp_rdata), int'(exp_mem[63]));
        check("b2b rsp1 addr", int'(rsp_addr), 63);
        step();

        op(2'b10, 6'd17, 4'h3, 1'b1, DEPTH, 4'h0);
        op(2'b00, 6'd0,  4'h0, 1'b0, 1, 4'h3);
        op(2'b00, 6'd31, 4'h0, 1'b0, 1, 4'h3);
        op(2'b00, 6'd63, 4'h0, 1'b0, 1, 4'h3);

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 19));
            cmd = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 10) ? 2'b01 : 2'b00;
            a = AW'($urandom);
            op(cmd, a, DW'($urandom), 1'b0,
               (cmd == 2'b10) ? DEPTH : (cmd == 2'b11) ? -1 : (cmd == 2'b01) ? WLAT : 1, exp_mem[a]);
        end

`ifdef RAM_MASTER_VERIFY_EN
        op(2'b01, 6'd9, 4'h7, 1'b0, 2, 4'h0);
        check("verify clean err", int'(err), 0);
        stuck_en = 1'b1;
        op(2'b01, 6'd9, 4'h7, 1'b0, 2, 4'h0);
        check("verify stuck err", int'(err), 1);
        stuck_en = 1'b0;
        op(2'b01, 6'd10, 4'h5, 1'b0, 2, 4'h0);
        check("err sticky", int'(err), 1);
`else
        check("err tied low", int'(err), 0);
`endif

        // Reset in the middle of a fill: words past the abort point stay untouched.
        for (int i = 0; i < DEPTH; i++) ram[i] = ~(DW'(i));
        req_valid = 1'b1; req_cmd = 2'b10; req_wdata = 4'h9;
        step();
        req_valid = 1'b0;
        r = 0;
        while (mem_addr != 6'd10 && r < 100) begin
            step();
            r++;
        end
        check("fill reached addr 10", int'(mem_addr), 10);
        rst_n = 1'b0;
        #1;
        check("async mem_we on reset", int'(mem_we), 1);
        repeat (3) step();
        bad = 0;
        for (int i = 0; i < 10; i++) if (ram[i] != 4'h9) bad++;
        for (int i = 11; i < DEPTH; i++) if (ram[i] != ~(DW'(i))) bad++;
        check("partial fill words", bad, 0);
        rst_n = 1'b1;
        step();
        check("post-reset outputs", int'({rsp_valid, done, err, mem_addr}), 0);
        check("post-reset ready", int'(req_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
